// File: rtl/carfield_eoc_scratch_regs.sv
// carfield_eoc_scratch_regs: scratch-register bus slave with an end-of-computation tracker.
// Software writes a start flag to reg0, later writes its exit status to the EOC register;
// the block latches the exit code and reports run/eoc/timeout status.
// Optional feature macro: CARFIELD_EOC_WATCHDOG_EN builds the RUN-cycle watchdog and the
// TIMEOUT path; without it timeout_o is tied low and wdog_limit_i is ignored.
module carfield_eoc_scratch_regs #(
  parameter int unsigned NumRegs   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned EocRegIdx = 1,
  parameter int unsigned WdogWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  input  logic [WdogWidth-1:0] wdog_limit_i,
  output logic                 run_o,
  output logic                 eoc_o,
  output logic                 timeout_o,
  output logic [30:0]          exit_code_o
);

  localparam int unsigned         IdxWidth = $clog2(NumRegs);
  localparam logic [IdxWidth-1:0] StartIdx = '0;
  localparam logic [IdxWidth-1:0] EocIdx   = IdxWidth'(EocRegIdx);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         regs_q [NumRegs];
  logic                rsp_valid_q;
  logic                rsp_error_q;
  logic [31:0]         rsp_rdata_q;
  logic [30:0]         exit_code_q;

  logic                accept;
  logic                addr_err;
  logic                wr_en;
  logic                start_hit;
  logic                eoc_hit;
  logic                enter_run;
  logic                enter_done;
  logic                wdog_expire;
  logic [IdxWidth-1:0] idx;
  logic [31:0]         wmask;
  logic [31:0]         merged;

  // Only one request may be outstanding, so a pending response blocks new requests.
  assign req_ready_o = !rsp_valid_q;
  assign accept      = req_valid_i && req_ready_o;

  // Word index plus error on misalignment or any address bit beyond the register window.
  assign idx      = req_addr_i[2 +: IdxWidth];
  assign addr_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (IdxWidth + 2)) != '0);
  assign wr_en    = accept && req_write_i && !addr_err;

  // Expand byte strobes into a bit mask for the read-modify-write merge.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{req_wstrb_i[b]}};
    end
  end

  assign merged = (regs_q[idx] & ~wmask) | (req_wdata_i & wmask);

  // Command decode: bit 0 of reg0 starts a run, bit 0 of the EOC register ends it.
  assign start_hit  = wr_en && (idx == StartIdx) && req_wstrb_i[0] && req_wdata_i[0];
  assign eoc_hit    = wr_en && (idx == EocIdx) && req_wstrb_i[0] && req_wdata_i[0];
  assign enter_run  = start_hit && (state_q != ST_RUN);
  assign enter_done = eoc_hit && (state_q == ST_RUN);

  // Scratch register file; strobe-less writes leave contents untouched via the merge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[idx] <= merged;
    end
  end

  // Response channel: capture on accept, hold until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_error_q <= addr_err;
      rsp_rdata_q <= (!req_write_i && !addr_err) ? regs_q[idx] : '0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

`ifdef CARFIELD_EOC_WATCHDOG_EN
  logic [WdogWidth-1:0] wdog_cnt_q;

  // Saturating count of cycles spent in RUN, cleared on every entry into RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
    end else if (enter_run) begin
      wdog_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && (wdog_cnt_q != '1)) begin
      wdog_cnt_q <= wdog_cnt_q + WdogWidth'(1);
    end
  end

  assign wdog_expire = (state_q == ST_RUN) && (wdog_limit_i != '0) &&
                       (wdog_cnt_q == wdog_limit_i - WdogWidth'(1));
  assign timeout_o   = (state_q == ST_TIMEOUT);
`else
  logic unused_wdog_limit;

  assign unused_wdog_limit = ^wdog_limit_i;
  assign wdog_expire       = 1'b0;
  assign timeout_o         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an EOC write beats a same-cycle watchdog expiry; DONE/TIMEOUT wait for a restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (eoc_hit) begin
          state_d = ST_DONE;
        end else if (wdog_expire) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: begin
        if (start_hit) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Exit code: cleared on restart, takes the merged EOC word on completion, all ones on timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_code_q <= '0;
    end else if (enter_run) begin
      exit_code_q <= '0;
    end else if (enter_done) begin
      exit_code_q <= merged[31:1];
    end else if (wdog_expire) begin
      exit_code_q <= '1;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign run_o       = (state_q == ST_RUN);
  assign eoc_o       = (state_q == ST_DONE);
  assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_carfield_eoc_scratch_regs.sv
// tb_carfield_eoc_scratch_regs: directed plus randomized bench for the EOC scratch registers.
// Watchdog expectations follow CARFIELD_EOC_WATCHDOG_EN exactly as the design build does.
`timescale 1ns/1ps
module tb_carfield_eoc_scratch_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] wdog_limit;
  logic        run;
  logic        eoc;
  logic        timeout;
  logic [30:0] exit_code;

  int check_count = 0;
  int error_count = 0;

  logic [31:0] last_rdata;
  logic        last_error;
  logic        last_valid;

  always #5 clk = ~clk;

  carfield_eoc_scratch_regs dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_wstrb_i  (req_wstrb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .wdog_limit_i (wdog_limit),
    .run_o        (run),
    .eoc_o        (eoc),
    .timeout_o    (timeout),
    .exit_code_o  (exit_code)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: four words of storage, a running/done/timed-out status and elapsed RUN cycles.
  logic [31:0] m_regs [4];
  bit          m_running;
  bit          m_done;
  bit          m_timed_out;
  bit          m_rsp_valid;
  bit          m_rsp_error;
  logic [31:0] m_rsp_rdata;
  logic [30:0] m_exit;
  int unsigned m_run_cycles;

  always @(posedge clk or negedge rst_n) begin : model
    bit          accepted;
    bit          bad;
    bit          was_running;
    bit          start_now;
    bit          eoc_now;
    int unsigned slot;
    logic [31:0] merged;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_running    = 1'b0;
      m_done       = 1'b0;
      m_timed_out  = 1'b0;
      m_rsp_valid  = 1'b0;
      m_rsp_error  = 1'b0;
      m_rsp_rdata  = '0;
      m_exit       = '0;
      m_run_cycles = 0;
    end else begin
      accepted    = req_valid && !m_rsp_valid;
      bad         = (req_addr % 4 != 0) || (req_addr >= 32'd16);
      slot        = req_addr / 4;
      merged      = '0;
      start_now   = 1'b0;
      eoc_now     = 1'b0;
      was_running = m_running;
      if (accepted) begin
        m_rsp_valid = 1'b1;
        m_rsp_error = bad;
        m_rsp_rdata = '0;
        if (!bad && !req_write) m_rsp_rdata = m_regs[slot];
        if (!bad && req_write) begin
          merged = m_regs[slot];
          for (int b = 0; b < 4; b++) begin
            if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
          end
          m_regs[slot] = merged;
          start_now = (slot == 0) && req_wstrb[0] && req_wdata[0];
          eoc_now   = (slot == 1) && req_wstrb[0] && req_wdata[0];
        end
      end else if (m_rsp_valid && rsp_ready) begin
        m_rsp_valid = 1'b0;
      end
      if (was_running) begin
        if (eoc_now) begin
          m_running = 1'b0;
          m_done    = 1'b1;
          m_exit    = merged[31:1];
        end
`ifdef CARFIELD_EOC_WATCHDOG_EN
        else if (wdog_limit != 0 && m_run_cycles + 1 == wdog_limit) begin
          m_running   = 1'b0;
          m_timed_out = 1'b1;
          m_exit      = '1;
        end
`endif
        else begin
          m_run_cycles++;
        end
      end else if (start_now) begin
        m_running    = 1'b1;
        m_done       = 1'b0;
        m_timed_out  = 1'b0;
        m_exit       = '0;
        m_run_cycles = 0;
      end
    end
  end

  // Every cycle: DUT outputs against the model, response payload only while a response is valid.
  always @(negedge clk) begin
    checkOutput("cmp_req_ready", 32'(req_ready), 32'(!m_rsp_valid));
    checkOutput("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    checkOutput("cmp_run", 32'(run), 32'(m_running));
    checkOutput("cmp_eoc", 32'(eoc), 32'(m_done));
    checkOutput("cmp_timeout", 32'(timeout), 32'(m_timed_out));
    checkOutput("cmp_exit_code", 32'(exit_code), 32'(m_exit));
    if (m_rsp_valid) begin
      checkOutput("cmp_rsp_rdata", rsp_rdata, m_rsp_rdata);
      checkOutput("cmp_rsp_error", 32'(rsp_error), 32'(m_rsp_error));
    end
  end

  // One complete transaction with the response consumer ready; captures the response.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    int wait_cycles;
    @(negedge clk);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = data;
    req_wstrb   = strb;
    wait_cycles = 0;
    while (req_ready !== 1'b1 && wait_cycles < 100) begin
      @(negedge clk);
      wait_cycles++;
    end
    checkOutput("accept_within_bound", 32'(wait_cycles < 100), 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    last_valid = rsp_valid;
    last_rdata = rsp_rdata;
    last_error = rsp_error;
  endtask

  task automatic checkReadZero(input logic [31:0] addr);
    applyStimulus(1'b0, addr, 32'h0, 4'hF);
    checkOutput("idle_read_valid", 32'(last_valid), 32'd1);
    checkOutput("idle_read_rdata", last_rdata, 32'h0);
    checkOutput("idle_read_error", 32'(last_error), 32'd0);
  endtask

  initial begin : global_guard
    #600000;
    $display("[TB] FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "[TB] bench exceeded time limit");
  end

  initial begin : stimulus
    int n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    rsp_ready  = 1'b1;
    wdog_limit = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_error", 32'(rsp_error), 32'd0);
    checkOutput("reset_run", 32'(run), 32'd0);
    checkOutput("reset_eoc", 32'(eoc), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_exit", 32'(exit_code), 32'd0);
    rst_n = 1'b1;

    $display("[TB] reads after reset");
    for (int a = 0; a < 4; a++) checkReadZero(32'(a * 4));
    checkOutput("idle_run", 32'(run), 32'd0);
    checkOutput("idle_eoc", 32'(eoc), 32'd0);

    $display("[TB] start then end of computation");
    applyStimulus(1'b1, 32'h0, 32'h1, 4'h1);
    checkOutput("start_run", 32'(run), 32'd1);
    applyStimulus(1'b1, 32'h4, 32'h0000_002B, 4'hF);
    checkOutput("eoc_flag", 32'(eoc), 32'd1);
    checkOutput("eoc_exit_code", 32'(exit_code), 32'd21);
    checkOutput("eoc_run_low", 32'(run), 32'd0);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF);
    checkOutput("eoc_readback", last_rdata, 32'h0000_002B);

    $display("[TB] watchdog limit 100");
    @(negedge clk);
    wdog_limit = 32'd100;
    applyStimulus(1'b1, 32'h0, 32'h1, 4'h1);
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
`ifdef CARFIELD_EOC_WATCHDOG_EN
    checkOutput("timeout_latency", 32'(n), 32'd100);
    checkOutput("timeout_exit_code", 32'(exit_code), 32'h7FFF_FFFF);
    checkOutput("timeout_run_low", 32'(run), 32'd0);
`else
    checkOutput("no_wdog_timeout_low", 32'(timeout), 32'd0);
    checkOutput("no_wdog_still_run", 32'(run), 32'd1);
`endif

    $display("[TB] watchdog disabled by limit 0");
    @(negedge clk);
    wdog_limit = 32'd0;
    applyStimulus(1'b1, 32'h0, 32'h1, 4'h1);
    repeat (10000) @(negedge clk);
    checkOutput("limit0_run", 32'(run), 32'd1);
    checkOutput("limit0_timeout", 32'(timeout), 32'd0);

    $display("[TB] EOC and watchdog expiry in the same cycle");
    applyStimulus(1'b1, 32'h4, 32'h1, 4'h1);
    checkOutput("pre_collision_eoc", 32'(eoc), 32'd1);
    @(negedge clk);
    wdog_limit = 32'd2;
    applyStimulus(1'b1, 32'h0, 32'h1, 4'h1);
    applyStimulus(1'b1, 32'h4, 32'h0000_0011, 4'hF);
    checkOutput("collision_eoc", 32'(eoc), 32'd1);
    checkOutput("collision_timeout", 32'(timeout), 32'd0);
    checkOutput("collision_exit", 32'(exit_code), 32'd8);
    @(negedge clk);
    wdog_limit = 32'd0;

    $display("[TB] error accesses");
    applyStimulus(1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF);
    checkOutput("err_unaligned", 32'(last_error), 32'd1);
    checkOutput("err_unaligned_rdata", last_rdata, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    checkOutput("err_range_write", 32'(last_error), 32'd1);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF);
    checkOutput("err_range_read", 32'(last_error), 32'd1);
    checkOutput("err_range_rdata", last_rdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF);
    checkOutput("err_reg0_kept", last_rdata, 32'h1);
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF);
    checkOutput("err_reg1_kept", last_rdata, 32'h0000_0011);
    checkOutput("err_state_kept", 32'(eoc), 32'd1);

    $display("[TB] response backpressure");
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h4;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_rdata", rsp_rdata, 32'h0000_0011);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_released", 32'(rsp_valid), 32'd0);

    $display("[TB] reset with a response pending in RUN");
    applyStimulus(1'b1, 32'h0, 32'h1, 4'h1);
    checkOutput("rst_pre_run", 32'(run), 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rst_pending", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_async_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_async_run", 32'(run), 32'd0);
    checkOutput("rst_async_eoc", 32'(eoc), 32'd0);
    checkOutput("rst_async_exit", 32'(exit_code), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 32'h4, 32'h0, 4'hF);
    checkOutput("post_rst_valid", 32'(last_valid), 32'd1);
    checkOutput("post_rst_rdata", last_rdata, 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
      req_wstrb = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (i % 400 == 0) wdog_limit = 32'($urandom_range(0, 40));
      case ($urandom_range(0, 6))
        0, 1: req_addr = 32'($urandom_range(0, 3)) << 2;
        2: begin
          req_addr     = 32'h0;
          req_write    = 1'b1;
          req_wdata[0] = 1'b1;
          req_wstrb[0] = 1'b1;
        end
        3: begin
          req_addr     = 32'h4;
          req_write    = 1'b1;
          req_wdata[0] = 1'b1;
          req_wstrb[0] = 1'b1;
        end
        4: req_addr = (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(1, 3));
        5: req_addr = 32'h10 + 32'($urandom_range(0, 1023));
        default: req_addr = $urandom;
      endcase
      if (i == 1700) begin
        #2 rst_n = 1'b0;
      end
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
